microcode_sequencer_ext: RTL and testbench

Parametrised next-generation micro-program sequencer. Adds a wider micro-PC, micro-jumps, and a micro-subroutine call/return stack. Keeps the end/halt/wait-state semantics of the current micro-PC. Builds the control-store micro-address from machine state, IR, condition, index and uPC. The control store itself stays external: this block drives its address and takes back the sequencing micro-ops.

---
 rtl/microcode_sequencer_ext.sv | 157 +++++++++++++++
 tb/tb_microcode_sequencer_ext.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer_ext.sv
// microcode_sequencer_ext
//   Micro-program sequencer with wide micro-PC, micro-jumps and a small
//   micro-subroutine return stack. The control store is external: this block
//   drives the micro-address and receives the sequencing micro-ops back.
//
//   Optional build macro: MSEQ_WATCHDOG_EN
//     defined   -> 8-bit watchdog counter, sticky wdog flag at WDOG_LIMIT
//     undefined -> no counter, wdog tied low
//
//   Ports
//     clk, reset         clock, synchronous active-high reset
//     nrsthold, nirqsuc  machine-state bits (top of micro-address)
//     ir, in_rsvd        instruction bits, reserved-instruction flag
//     ncond, idx         condition (active low), addressing-mode index
//     nhalt, nws         halt / wait state, active low, freeze sequencing
//     nendext, nend      end of instruction (external / microcode), active low
//     ujmp, ucall, uret  sequencing micro-ops, utarget their target
//     uaddr              {nrsthold,nirqsuc,ir,in_rsvd,ncond,idx,upc}
//     upc, fpfetch       micro-PC, fetch phase (upc < 2)
//     sdepth, serr       stack occupancy, sticky overflow/underflow
//     wdog               watchdog trip
module microcode_sequencer_ext #(
  parameter int UPC_W       = 4,
  parameter int IR_W        = 9,
  parameter int IDX_W       = 2,
  parameter int STACK_DEPTH = 2,
  parameter int WDOG_LIMIT  = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            nrsthold,
  input  logic                            nirqsuc,
  input  logic [IR_W-1:0]                 ir,
  input  logic                            in_rsvd,
  input  logic                            ncond,
  input  logic [IDX_W-1:0]                idx,
  input  logic                            nhalt,
  input  logic                            nws,
  input  logic                            nendext,
  input  logic                            nend,
  input  logic                            ujmp,
  input  logic                            ucall,
  input  logic                            uret,
  input  logic [UPC_W-1:0]                utarget,
  output logic [4+IR_W+IDX_W+UPC_W-1:0]   uaddr,
  output logic [UPC_W-1:0]                upc,
  output logic                            fpfetch,
  output logic [3:0]                      sdepth,
  output logic                            serr,
  output logic                            wdog
);

  if (UPC_W < 2 || UPC_W > 8)             $error("UPC_W out of range");
  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) $error("STACK_DEPTH out of range");
  if (WDOG_LIMIT < 1 || WDOG_LIMIT > 255) $error("WDOG_LIMIT out of range");

  logic [UPC_W-1:0] upc_q, upc_d;
  logic [3:0]       depth_q, depth_d;
  logic             serr_q, serr_d;
  logic [UPC_W-1:0] stack_q [STACK_DEPTH];
  logic [UPC_W-1:0] stack_d [STACK_DEPTH];
  logic [UPC_W-1:0] top;
  logic             do_end, hold;

  // End overrides hold, like a parallel load on a '161 counter.
  assign do_end = !nend || !nendext;
  assign hold   = !nhalt || !nws;

  always_comb begin
    upc_d   = upc_q;
    depth_d = depth_q;
    serr_d  = serr_q;
    stack_d = stack_q;
    top     = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (depth_q == 4'(i + 1)) top = stack_q[i];

    if (do_end) begin
      upc_d   = '0;
      depth_d = '0;
    end else if (!hold) begin
      if (uret) begin
        if (depth_q != 4'd0) begin
          upc_d   = top;
          depth_d = depth_q - 4'd1;
        end else begin
          upc_d  = '0;
          serr_d = 1'b1;
        end
      end else if (ucall) begin
        if (depth_q < 4'(STACK_DEPTH)) begin
          for (int i = 0; i < STACK_DEPTH; i++)
            if (depth_q == 4'(i)) stack_d[i] = upc_q + UPC_W'(1);
          depth_d = depth_q + 4'd1;
        end else begin
          serr_d = 1'b1;
        end
        upc_d = utarget;
      end else if (ujmp) begin
        upc_d = utarget;
      end else begin
        upc_d = upc_q + UPC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q   <= '0;
      depth_q <= '0;
      serr_q  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      upc_q   <= upc_d;
      depth_q <= depth_d;
      serr_q  <= serr_d;
      stack_q <= stack_d;
    end
  end

`ifdef MSEQ_WATCHDOG_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       wdog_q, wdog_d;

  // Counter saturates so a late trip can never be missed by wrapping.
  always_comb begin
    wcnt_d = wcnt_q;
    wdog_d = wdog_q;
    if (do_end)
      wcnt_d = '0;
    else if (!hold && wcnt_q != 8'hFF)
      wcnt_d = wcnt_q + 8'd1;
    if (wcnt_d == 8'(WDOG_LIMIT)) wdog_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog = wdog_q;
`else
  assign wdog = 1'b0;
`endif

  assign uaddr   = {nrsthold, nirqsuc, ir, in_rsvd, ncond, idx, upc_q};
  assign upc     = upc_q;
  assign fpfetch = (upc_q < UPC_W'(2));
  assign sdepth  = depth_q;
  assign serr    = serr_q;

endmodule

// File: tb/tb_microcode_sequencer_ext.sv
module tb_microcode_sequencer_ext;
  localparam int UPC_W = 4, IR_W = 9, IDX_W = 2, DEPTH = 2, WLIM = 20;
  localparam int AW = 4 + IR_W + IDX_W + UPC_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nrsthold = 1'b1, nirqsuc = 1'b1, in_rsvd = 1'b0, ncond = 1'b1;
  logic [IR_W-1:0] ir = '0;
  logic [IDX_W-1:0] idx = '0;
  logic nhalt = 1'b1, nws = 1'b1, nendext = 1'b1, nend = 1'b1;
  logic ujmp = 1'b0, ucall = 1'b0, uret = 1'b0;
  logic [UPC_W-1:0] utarget = '0;
  logic [AW-1:0] uaddr;
  logic [UPC_W-1:0] upc;
  logic fpfetch, serr, wdog;
  logic [3:0] sdepth;

  int n_chk = 0, n_fail = 0;
  bit check_en = 0;

  microcode_sequencer_ext #(.UPC_W(UPC_W), .IR_W(IR_W), .IDX_W(IDX_W),
    .STACK_DEPTH(DEPTH), .WDOG_LIMIT(WLIM)) dut (
    .clk(clk), .reset(reset), .nrsthold(nrsthold), .nirqsuc(nirqsuc),
    .ir(ir), .in_rsvd(in_rsvd), .ncond(ncond), .idx(idx), .nhalt(nhalt),
    .nws(nws), .nendext(nendext), .nend(nend), .ujmp(ujmp), .ucall(ucall),
    .uret(uret), .utarget(utarget), .uaddr(uaddr), .upc(upc),
    .fpfetch(fpfetch), .sdepth(sdepth), .serr(serr), .wdog(wdog));

  always #5 clk = ~clk;

  // Behavioural model: stack as a queue, plain integer micro-PC.
  int m_upc = 0, m_wcnt = 0;
  int stk[$];
  bit m_serr = 0, m_wdog = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_upc = 0; stk.delete(); m_serr = 0; m_wcnt = 0; m_wdog = 0;
    end else if (!nend || !nendext) begin
      m_upc = 0; stk.delete(); m_wcnt = 0;
    end else if (nhalt && nws) begin
      if (m_wcnt < 255) m_wcnt++;
      if (m_wcnt == WLIM) m_wdog = 1;
      if (uret) begin
        if (stk.size() > 0) m_upc = stk.pop_back();
        else begin m_upc = 0; m_serr = 1; end
      end else if (ucall) begin
        if (stk.size() < DEPTH) stk.push_back((m_upc + 1) % (1 << UPC_W));
        else m_serr = 1;
        m_upc = int'(utarget);
      end else if (ujmp) begin
        m_upc = int'(utarget);
      end else begin
        m_upc = (m_upc + 1) % (1 << UPC_W);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [AW-1:0] exp_addr;
      int exp_wdog;
`ifdef MSEQ_WATCHDOG_EN
      exp_wdog = int'(m_wdog);
`else
      exp_wdog = 0;
`endif
      exp_addr = {nrsthold, nirqsuc, ir, in_rsvd, ncond, idx, UPC_W'(m_upc)};
      chk("cyc_upc", int'(upc), m_upc);
      chk("cyc_sdepth", int'(sdepth), stk.size());
      chk("cyc_serr", int'(serr), int'(m_serr));
      chk("cyc_fpfetch", int'(fpfetch), int'(m_upc < 2));
      chk("cyc_wdog", int'(wdog), exp_wdog);
      chk("cyc_uaddr", int'(uaddr), int'(exp_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ir = IR_W'($urandom); idx = IDX_W'($urandom);
    ncond = 1'($urandom); in_rsvd = 1'($urandom);
    nrsthold = 1'($urandom); nirqsuc = 1'($urandom);
  endtask

  task automatic idle();
    ujmp = 0; ucall = 0; uret = 0; nhalt = 1; nws = 1; nend = 1; nendext = 1;
  endtask

  task automatic op(input bit j, input bit c, input bit r, input int tgt);
    ujmp = j; ucall = c; uret = r; utarget = UPC_W'(tgt);
    tick();
    idle();
  endtask

  initial begin
    reset = 1; idle();
    tick(); tick();
    check_en = 1;
    reset = 0;
    chk("rst_upc", int'(upc), 0);
    chk("rst_sdepth", int'(sdepth), 0);
    chk("rst_serr", int'(serr), 0);
    chk("rst_fpfetch", int'(fpfetch), 1);
    chk("rst_wdog", int'(wdog), 0);

    // free run after reset
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("run_upc", int'(upc), i);
      chk("run_fpfetch", int'(fpfetch), (i < 2) ? 1 : 0);
    end

    // wrap 15 -> 0
    reset = 1; tick(); reset = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("wrap_upc15", int'(upc), 15);
    end
    chk("wrap_upc0", int'(upc), 0);
    chk("wrap_serr", int'(serr), 0);

    // call / return
    tick(); tick(); tick();
    chk("call_pre", int'(upc), 3);
    op(0, 1, 0, 9);
    chk("call_upc", int'(upc), 9);
    chk("call_depth", int'(sdepth), 1);
    tick();
    chk("call_upc10", int'(upc), 10);
    op(0, 0, 1, 0);
    chk("ret_upc", int'(upc), 4);
    chk("ret_depth", int'(sdepth), 0);

    // nested calls, overflow, underflow
    op(0, 1, 0, 8);
    op(0, 1, 0, 12);
    chk("nest2_depth", int'(sdepth), 2);
    op(0, 1, 0, 2);
    chk("ovf_upc", int'(upc), 2);
    chk("ovf_depth", int'(sdepth), 2);
    chk("ovf_serr", int'(serr), 1);
    op(0, 0, 1, 0);
    chk("pop1_upc", int'(upc), 9);
    op(0, 0, 1, 0);
    chk("pop2_upc", int'(upc), 5);
    op(0, 0, 1, 0);
    chk("unf_upc", int'(upc), 0);
    chk("unf_serr", int'(serr), 1);

    // priority between micro-ops
    op(1, 1, 0, 7);
    chk("pri_call_upc", int'(upc), 7);
    chk("pri_call_depth", int'(sdepth), 1);
    op(1, 0, 0, 3);
    chk("jmp_upc", int'(upc), 3);
    op(1, 1, 1, 11);
    chk("pri_ret_upc", int'(upc), 1);
    chk("pri_ret_depth", int'(sdepth), 0);

    // wait / halt hold, then end during wait
    op(0, 1, 0, 6);
    nws = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("ws_upc", int'(upc), 6);
    chk("ws_depth", int'(sdepth), 1);
    nhalt = 0; nws = 1; ujmp = 1; utarget = 4'd13;
    tick(); idle();
    chk("halt_upc", int'(upc), 6);
    nws = 0; nend = 0;
    tick(); idle();
    chk("end_upc", int'(upc), 0);
    chk("end_depth", int'(sdepth), 0);
    chk("end_serr", int'(serr), 1);
    op(0, 1, 0, 5);
    nhalt = 0; nendext = 0; uret = 1;
    tick(); idle();
    chk("endext_upc", int'(upc), 0);
    chk("endext_depth", int'(sdepth), 0);

    // reset mid-call
    op(0, 1, 0, 5);
    reset = 1; ucall = 1; utarget = 4'd9;
    tick(); reset = 0; idle();
    chk("rstmid_upc", int'(upc), 0);
    chk("rstmid_depth", int'(sdepth), 0);
    chk("rstmid_serr", int'(serr), 0);

    // watchdog: held cycles do not count, trip on 20th counted edge
    nhalt = 0;
    for (int i = 0; i < 30; i++) tick();
    chk("wd_held", int'(wdog), 0);
    nhalt = 1;
    for (int i = 0; i < 19; i++) tick();
    chk("wd_19", int'(wdog), 0);
    tick();
`ifdef MSEQ_WATCHDOG_EN
    chk("wd_20", int'(wdog), 1);
`else
    chk("wd_20", int'(wdog), 0);
`endif
    for (int i = 0; i < 5; i++) tick();

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
